vrf_read_issue: RTL and testbench



---
 rtl/vrf_read_pkg.sv | 23 ++
 rtl/vrf_read_resp_fifo.sv | 57 +++++
 rtl/vrf_read_issue.sv | 134 +++++++++++++
 tb/tb_vrf_read_issue.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vrf_read_pkg.sv
// Shared widths, the read tag carried alongside each VRF read, and the bank address packing.
package vrf_read_pkg;

  localparam int VS_W     = 5;
  localparam int OFFSET_W = 9;
  localparam int SOURCE_W = 4;
  localparam int INST_W   = 3;
  localparam int ADDR_W   = 14;
  localparam int TAG_W    = SOURCE_W + INST_W;

  typedef struct packed {
    logic [SOURCE_W-1:0] read_source;
    logic [INST_W-1:0]   instruction_index;
  } read_tag_t;

  function automatic logic [ADDR_W-1:0] make_addr(
    input logic [VS_W-1:0]     vs,
    input logic [OFFSET_W-1:0] offset
  );
    return {vs, offset};
  endfunction

endpackage

// File: rtl/vrf_read_resp_fifo.sv
// Response FIFO: DEPTH entries of W bits, registered output, pointers wrap modulo DEPTH
// (DEPTH need not be a power of two). Push on a full FIFO or pop on an empty one is ignored.
module vrf_read_resp_fifo
  import vrf_read_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     pop_data,
  output logic             not_empty,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign not_empty = (count != '0);
  assign do_push   = push & (count != CNT_W'(DEPTH));
  assign do_pop    = pop & not_empty;
  assign pop_data  = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset: contents are only observed behind the count.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/vrf_read_issue.sv
// Issues arbitrated VRF reads, tracks them through the bank latency and buffers tagged data.
// Optional VRF_READ_BYPASS_EN: returning data skips an empty FIFO and is presented the same cycle.
module vrf_read_issue
  import vrf_read_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 2,
  parameter int RESP_DEPTH   = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                io_req_valid,
  output logic                io_req_ready,
  input  logic [VS_W-1:0]     io_req_bits_vs,
  input  logic [OFFSET_W-1:0] io_req_bits_offset,
  input  logic [SOURCE_W-1:0] io_req_bits_readSource,
  input  logic [INST_W-1:0]   io_req_bits_instructionIndex,
  input  logic                io_vrfBlock,
  output logic                io_vrf_readEn,
  output logic [ADDR_W-1:0]   io_vrf_addr,
  input  logic [DATA_W-1:0]   io_vrf_readData,
  output logic                io_resp_valid,
  input  logic                io_resp_ready,
  output logic [DATA_W-1:0]   io_resp_bits_data,
  output logic [SOURCE_W-1:0] io_resp_bits_readSource,
  output logic [INST_W-1:0]   io_resp_bits_instructionIndex
);

  localparam int CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int PAY_W = DATA_W + TAG_W;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(RESP_DEPTH);

  logic                    fire;
  read_tag_t               req_tag;
  logic [READ_LATENCY-1:0] pipe_valid;
  read_tag_t               pipe_tag [READ_LATENCY];
  logic                    tail_valid;
  read_tag_t               tail_tag;
  logic [CNT_W-1:0]        inflight;
  logic [CNT_W-1:0]        fifo_count;
  logic [CNT_W:0]          used;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_valid;
  logic [PAY_W-1:0]        fifo_out;
  logic [DATA_W-1:0]       fifo_data;
  read_tag_t               fifo_tag;

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1. req_ready
  // never looks at req_valid or resp_ready; resp_valid/bits hold until resp_ready takes them.
  // A credit freed by a same-cycle dequeue is only usable the following cycle.
  assign used         = {1'b0, inflight} + {1'b0, fifo_count};
  assign io_req_ready = ~io_vrfBlock & (used < DEPTH_C);
  assign fire         = io_req_valid & io_req_ready;

  assign io_vrf_readEn = fire;
  assign io_vrf_addr   = make_addr(io_req_bits_vs, io_req_bits_offset);

  assign req_tag.read_source       = io_req_bits_readSource;
  assign req_tag.instruction_index = io_req_bits_instructionIndex;

  always_ff @(posedge clock) begin
    if (reset) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= fire;
      for (int i = 1; i < READ_LATENCY; i++) pipe_valid[i] <= pipe_valid[i-1];
    end
  end

  always_ff @(posedge clock) begin
    if (fire) pipe_tag[0] <= req_tag;
    for (int i = 1; i < READ_LATENCY; i++) pipe_tag[i] <= pipe_tag[i-1];
  end

  assign tail_valid = pipe_valid[READ_LATENCY-1];
  assign tail_tag   = pipe_tag[READ_LATENCY-1];

  // Running count of valid pipe stages; kept as a counter so the credit compare is shallow.
  always_ff @(posedge clock) begin
    if (reset) begin
      inflight <= '0;
    end else begin
      case ({fire, tail_valid})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  vrf_read_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .W     (PAY_W)
  ) u_resp_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({io_vrf_readData, tail_tag}),
    .pop       (fifo_pop),
    .pop_data  (fifo_out),
    .not_empty (fifo_valid),
    .count     (fifo_count)
  );

  assign {fifo_data, fifo_tag} = fifo_out;
  assign fifo_pop = fifo_valid & io_resp_ready;

`ifdef VRF_READ_BYPASS_EN
  logic bypass;

  // Only an empty FIFO may be bypassed, so issue order is preserved.
  assign bypass        = tail_valid & ~fifo_valid;
  assign fifo_push     = tail_valid & ~(bypass & io_resp_ready);
  assign io_resp_valid = fifo_valid | bypass;
  assign io_resp_bits_data             = bypass ? io_vrf_readData : fifo_data;
  assign io_resp_bits_readSource       = bypass ? tail_tag.read_source : fifo_tag.read_source;
  assign io_resp_bits_instructionIndex = bypass ? tail_tag.instruction_index
                                                : fifo_tag.instruction_index;
`else
  assign fifo_push     = tail_valid;
  assign io_resp_valid = fifo_valid;
  assign io_resp_bits_data             = fifo_data;
  assign io_resp_bits_readSource       = fifo_tag.read_source;
  assign io_resp_bits_instructionIndex = fifo_tag.instruction_index;
`endif

  a_inflight_matches_pipe : assert property (@(posedge clock) disable iff (reset)
    inflight == CNT_W'($countones(pipe_valid)));

  a_no_push_when_full : assert property (@(posedge clock) disable iff (reset)
    !(fifo_push && fifo_count == CNT_W'(RESP_DEPTH)));

endmodule

// File: tb/tb_vrf_read_issue.sv
// Directed bench for vrf_read_issue: bank model, request-side expectation push, response scoreboard.
module tb_vrf_read_issue;

  localparam int DATA_W       = 32;
  localparam int READ_LATENCY = 2;
  localparam int RESP_DEPTH   = 4;
`ifdef VRF_READ_BYPASS_EN
  localparam int RESP_LAT = READ_LATENCY;
`else
  localparam int RESP_LAT = READ_LATENCY + 1;
`endif
  localparam int PAY_W = DATA_W + 7;

  logic              clock = 1'b0;
  logic              reset;
  logic              io_req_valid;
  logic              io_req_ready;
  logic [4:0]        io_req_bits_vs;
  logic [8:0]        io_req_bits_offset;
  logic [3:0]        io_req_bits_readSource;
  logic [2:0]        io_req_bits_instructionIndex;
  logic              io_vrfBlock;
  logic              io_vrf_readEn;
  logic [13:0]       io_vrf_addr;
  logic [DATA_W-1:0] io_vrf_readData;
  logic              io_resp_valid;
  logic              io_resp_ready;
  logic [DATA_W-1:0] io_resp_bits_data;
  logic [3:0]        io_resp_bits_readSource;
  logic [2:0]        io_resp_bits_instructionIndex;

  logic [PAY_W-1:0]  exp_q[$];
  int                n_vec  = 0;
  int                n_fail = 0;
  int                n_resp = 0;

  vrf_read_issue #(
    .DATA_W       (DATA_W),
    .READ_LATENCY (READ_LATENCY),
    .RESP_DEPTH   (RESP_DEPTH)
  ) dut (
    .clock                         (clock),
    .reset                         (reset),
    .io_req_valid                  (io_req_valid),
    .io_req_ready                  (io_req_ready),
    .io_req_bits_vs                (io_req_bits_vs),
    .io_req_bits_offset            (io_req_bits_offset),
    .io_req_bits_readSource        (io_req_bits_readSource),
    .io_req_bits_instructionIndex  (io_req_bits_instructionIndex),
    .io_vrfBlock                   (io_vrfBlock),
    .io_vrf_readEn                 (io_vrf_readEn),
    .io_vrf_addr                   (io_vrf_addr),
    .io_vrf_readData               (io_vrf_readData),
    .io_resp_valid                 (io_resp_valid),
    .io_resp_ready                 (io_resp_ready),
    .io_resp_bits_data             (io_resp_bits_data),
    .io_resp_bits_readSource       (io_resp_bits_readSource),
    .io_resp_bits_instructionIndex (io_resp_bits_instructionIndex)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  function automatic logic [31:0] bank_f(input logic [13:0] a);
    return 32'hDEADB8F5 ^ {18'h0, a};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- bank model ----------------
  logic [DATA_W-1:0] bank_pipe [READ_LATENCY];
  always @(posedge clock) begin
    bank_pipe[0] <= io_vrf_readEn ? bank_f(io_vrf_addr) : 32'h0BAD0BAD;
    for (int i = 1; i < READ_LATENCY; i++) bank_pipe[i] <= bank_pipe[i-1];
  end
  assign io_vrf_readData = bank_pipe[READ_LATENCY-1];

  // ---------------- request side: strobe/address check, expectation push ----------------
  always @(negedge clock) begin
    if (!reset) begin
      check("read_en", io_vrf_readEn, io_req_valid && io_req_ready);
      if (io_req_valid && io_req_ready) begin
        check("vrf_addr", io_vrf_addr, {io_req_bits_vs, io_req_bits_offset});
        exp_q.push_back({bank_f({io_req_bits_vs, io_req_bits_offset}),
                         io_req_bits_readSource, io_req_bits_instructionIndex});
      end
    end
  end

  // ---------------- response scoreboard ----------------
  logic [PAY_W-1:0] mon_exp;
  always @(negedge clock) begin
    if (!reset && io_resp_valid && io_resp_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL stale_resp: got %0h/%0h/%0h expected no response at %0t",
                 io_resp_bits_data, io_resp_bits_readSource, io_resp_bits_instructionIndex, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("resp_payload",
              {io_resp_bits_data, io_resp_bits_readSource, io_resp_bits_instructionIndex}, mon_exp);
        n_resp++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i);
    io_req_bits_vs               = 5'(i + 1);
    io_req_bits_offset           = 9'(i * 37);
    io_req_bits_readSource       = 4'(i);
    io_req_bits_instructionIndex = 3'(i + i / 8);
  endtask

  task automatic drive_req(input logic [4:0] vs, input logic [8:0] off,
                           input logic [3:0] src, input logic [2:0] inst);
    bit done;
    done = 1'b0;
    io_req_valid                 = 1'b1;
    io_req_bits_vs               = vs;
    io_req_bits_offset           = off;
    io_req_bits_readSource       = src;
    io_req_bits_instructionIndex = inst;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clock);
      done = io_req_ready;
      tick();
    end
    if (!done) check("req_timeout", 64'd0, 64'd1);
  endtask

  // ---------------- directed sequence ----------------
  int  n_acc;
  int  idx;
  int  base;
  bit  fired;

  initial begin
    reset         = 1'b1;
    io_req_valid  = 1'b0;
    io_vrfBlock   = 1'b0;
    io_resp_ready = 1'b1;
    set_req(0);

    // reset values
    tick();
    tick();
    @(negedge clock);
    check("rst_req_ready", io_req_ready, 1);
    check("rst_resp_valid", io_resp_valid, 0);
    check("rst_read_en", io_vrf_readEn, 0);
    tick();
    io_vrfBlock = 1'b1;
    @(negedge clock);
    check("rst_req_ready_blocked", io_req_ready, 0);
    tick();
    io_vrfBlock = 1'b0;
    reset       = 1'b0;
    tick();

    // single read, hand-computed response
    drive_req(5'd3, 9'h01A, 4'd5, 3'd2);
    io_req_valid = 1'b0;
    for (int k = 1; k <= RESP_LAT; k++) begin
      @(negedge clock);
      check("single_resp_valid", io_resp_valid, (k == RESP_LAT));
      if (k == RESP_LAT) begin
        check("single_data", io_resp_bits_data, 32'hDEADBEEF);
        check("single_source", io_resp_bits_readSource, 4'd5);
        check("single_inst", io_resp_bits_instructionIndex, 3'd2);
      end
    end
    repeat (3) tick();

    // response held while consumer stalls
    io_resp_ready = 1'b0;
    drive_req(5'd7, 9'h155, 4'hA, 3'd5);
    io_req_valid = 1'b0;
    for (int k = 1; k <= RESP_LAT + 1; k++) begin
      @(negedge clock);
      check("hold_resp_valid", io_resp_valid, (k >= RESP_LAT));
      if (k >= RESP_LAT) begin
        check("hold_data", io_resp_bits_data, 32'hDEADB7A0);
        check("hold_source", io_resp_bits_readSource, 4'hA);
        check("hold_inst", io_resp_bits_instructionIndex, 3'd5);
      end
    end
    tick();
    io_resp_ready = 1'b1;
    repeat (3) tick();
    check("hold_drained", exp_q.size(), 0);

    // back-pressure: six offered, four credits
    io_resp_ready = 1'b0;
    idx   = 0;
    n_acc = 0;
    set_req(idx);
    io_req_valid = 1'b1;
    repeat (8) begin
      @(negedge clock);
      fired = io_req_ready;
      tick();
      if (fired) begin
        n_acc++;
        idx++;
        if (idx < 6) set_req(idx);
        else io_req_valid = 1'b0;
      end
    end
    check("bp_accepted", n_acc, 4);
    @(negedge clock);
    check("bp_ready_full", io_req_ready, 0);
    tick();
    io_resp_ready = 1'b1;
    @(negedge clock);
    check("bp_ready_same_cycle_deq", io_req_ready, 0);
    tick();
    io_resp_ready = 1'b0;
    @(negedge clock);
    check("bp_ready_released", io_req_ready, 1);
    tick();
    io_req_valid  = 1'b0;
    io_resp_ready = 1'b1;
    repeat (12) tick();
    check("bp_drained", exp_q.size(), 0);

    // bank block with valid held
    io_vrfBlock = 1'b1;
    set_req(20);
    io_req_valid = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("blk_ready", io_req_ready, 0);
      tick();
    end
    io_vrfBlock = 1'b0;
    @(negedge clock);
    check("blk_release_ready", io_req_ready, 1);
    tick();
    io_req_valid = 1'b0;
    repeat (6) tick();
    check("blk_drained", exp_q.size(), 0);

    // streaming: 16 back-to-back reads
    base = n_resp;
    for (int i = 0; i < 16; i++) begin
      set_req(32 + i);
      io_req_valid = 1'b1;
      @(negedge clock);
      check("stream_ready", io_req_ready, 1);
      tick();
    end
    io_req_valid = 1'b0;
    repeat (RESP_LAT + 1) tick();
    check("stream_count", n_resp - base, 16);

    // reset with two reads in the pipe and one entry in the FIFO
    io_resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(50 + i);
      io_req_valid = 1'b1;
      @(negedge clock);
      check("rst_mid_issue_ready", io_req_ready, 1);
      tick();
    end
    io_req_valid = 1'b0;
    reset        = 1'b1;
    exp_q.delete();
    @(negedge clock);
    check("rst_mid_pre_valid", io_resp_valid, 1);
    tick();
    @(negedge clock);
    check("rst_mid_resp_valid", io_resp_valid, 0);
    check("rst_mid_req_ready", io_req_ready, 1);
    tick();
    reset         = 1'b0;
    io_resp_ready = 1'b1;
    repeat (10) tick();
    check("rst_mid_no_stale", exp_q.size(), 0);

    // normal operation after reset
    base = n_resp;
    drive_req(5'd31, 9'h1FF, 4'hF, 3'd7);
    io_req_valid = 1'b0;
    repeat (RESP_LAT + 2) tick();
    check("post_rst_count", n_resp - base, 1);
    check("final_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
